serial_adder: RTL

//   Parametrised bit-serial adder/subtractor: one full-adder slice plus a carry flip-flop

---
 rtl/serial_adder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor. One full-adder slice and a carry flop process
//   the operands LSB first, one bit per clock. A WIDTH-bit operation takes
//   WIDTH clocks in RUN, followed by a one-cycle DONE.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high; aborts any operation
//   start     in   1      request an operation (accepted in IDLE or DONE)
//   sub       in   1      0: a+b, 1: a-b (sampled with start)
//   a, b      in   WIDTH  operands (sampled with start)
//   busy      out  1      high while the serial slice is running
//   done      out  1      one-cycle pulse; result outputs valid from here on
//   sum       out  WIDTH  result modulo 2^WIDTH
//   cout      out  1      carry out of MSB (sub: 1 means no borrow)
//   overflow  out  1      signed overflow of the last completed operation
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             c_bit;

    // Single full-adder slice: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    always_comb begin
        {c_bit, s_bit} = full_add(a_sh_q[0], b_sh_q[0], carry_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST_BIT) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state / registered result
    always_comb begin
        busy     = (state_q == S_RUN);
        done     = (state_q == S_DONE);
        sum      = sum_q;
        cout     = cout_q;
        overflow = ovf_q;
    end

    // Datapath next-value logic
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry.
                    a_sh_d   = a;
                    b_sh_d   = sub ? ~b : b;
                    res_sh_d = '0;
                    carry_d  = sub;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {s_bit, res_sh_q[WIDTH-1:1]};
                carry_d  = c_bit;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB slice at this point.
                    sum_d  = {s_bit, res_sh_q[WIDTH-1:1]};
                    cout_d = c_bit;
                    ovf_d  = carry_q ^ c_bit;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
